multiplier_control: RTL

Sequencing FSM for the 32-bit shift-add multiplier. It sits directly upstream of the product register and ALU. It accepts a start request, loads the multiplier and multiplicand, then issues one add/shift step per cycle for exactly `ITER` cycles. Decisions are steered by the product LSB, and the block signals completion with a one-cycle `Done` pulse.

---
 rtl/multiplier_control.sv | 89 ++++++++
 1 files changed

// File: rtl/multiplier_control.sv
// Sequencing FSM for the shift-add multiplier: one LOAD cycle, ITER add/shift
// cycles steered by the product LSB, then a single-cycle Done pulse.
module multiplier_control #(
    parameter int unsigned ITER  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Product_lsb,
    output logic       W_ctrl,
    output logic       SRL_ctrl,
    output logic       Mcand_W_ctrl,
    output logic [1:0] ALU_sel,
    output logic       Ready,
    output logic       Done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CALC = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_PASS = 2'b01;
    localparam logic [1:0] SEL_ADD  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and iteration counter registers, cleared asynchronously.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and output decode; only ALU_sel in CALC
    // looks at an input (Product_lsb), every write strobe is state-only.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        W_ctrl       = 1'b0;
        SRL_ctrl     = 1'b0;
        Mcand_W_ctrl = 1'b0;
        ALU_sel      = SEL_ZERO;
        Ready        = 1'b0;
        Done         = 1'b0;

        case (state_q)
            IDLE: begin
                Ready = 1'b1;
                if (Run) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                W_ctrl       = 1'b1;
                Mcand_W_ctrl = 1'b1;
                cnt_d        = '0;
                state_d      = CALC;
            end
            CALC: begin
                SRL_ctrl = 1'b1;
                ALU_sel  = Product_lsb ? SEL_ADD : SEL_PASS;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
